// File: rtl/arith_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit arithmetic unit between two
// requesters; result is held on a single response channel until accepted.

module arith_unit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [7:0] y4,
  output logic [7:0] y5
);
  assign y1 = a + b;
  assign y2 = a - b;
  assign y3 = a * b;
  // Zero divisor yields 0 here; the arbiter substitutes its own error value.
  assign y4 = (b == 8'd0) ? 8'd0 : a / b;
  assign y5 = (b == 8'd0) ? 8'd0 : a % b;
endmodule

module arith_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [2:0] op0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [2:0] op1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last;
  logic        gnt;
  logic        grant_en;
  logic [7:0]  a_r, b_r;
  logic [2:0]  op_r;
  logic [7:0]  y1, y2, y3, y4, y5;
  logic [8:0]  result;

  // Maps the unit's outputs to {err, data} for the latched opcode.
  function automatic logic [8:0] capture(input logic [2:0] op, input logic [7:0] b,
                                         input logic [7:0] s1, input logic [7:0] s2,
                                         input logic [7:0] s3, input logic [7:0] s4,
                                         input logic [7:0] s5);
    case (op)
      3'd0:    return {1'b0, s1};
      3'd1:    return {1'b0, s2};
      3'd2:    return {1'b0, s3};
      3'd3:    return (b == 8'd0) ? {1'b1, 8'hFF} : {1'b0, s4};
      3'd4:    return (b == 8'd0) ? {1'b1, 8'hFF} : {1'b0, s5};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  arith_unit u_unit (
    .a  (a_r),
    .b  (b_r),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3),
    .y4 (y4),
    .y5 (y5)
  );

  assign result = capture(op_r, b_r, y1, y2, y3, y4, y5);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    gnt       = 1'b0;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_en  = 1'b1;
          gnt       = (&req_valid) ? ~last : req_valid[1];
          req_ready = gnt ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      op_r      <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        a_r    <= gnt ? a1 : a0;
        b_r    <= gnt ? b1 : b0;
        op_r   <= gnt ? op1 : op0;
        last   <= gnt;
        rsp_id <= gnt;
        cnt    <= CNT_INIT;
      end
      if (state == EXEC) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_data  <= result[7:0];
          rsp_err   <= result[8];
          rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
